// File: rtl/quadra_pkg.sv
// Shared types and sizing for the quadra pipeline and its output buffer.
package quadra_pkg;

    typedef logic [15:0] y_t;
    typedef logic        dv_t;

    localparam int QUADRA_LATENCY = 3;
    localparam int QBUF_DEPTH     = 8;

endpackage

// File: rtl/quadra_fifo_mem.sv
// Storage for the output buffer: synchronous write, asynchronous read so the
// head entry is visible in the same cycle it becomes valid (first-word-fall-through).
module quadra_fifo_mem
    import quadra_pkg::*;
#(
    parameter  int DEPTH = QBUF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  y_t            wr_data,
    input  logic [AW-1:0] rd_addr,
    output y_t            rd_data
);

    y_t mem [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/quadra_out_buf.sv
// Output buffer behind the non-stallable quadra pipeline: captures every result,
// hands it to a valid/ready consumer, and returns issue credits upstream.
module quadra_out_buf
    import quadra_pkg::*;
#(
    parameter int DEPTH   = QBUF_DEPTH,
    parameter int LATENCY = QUADRA_LATENCY,
    parameter int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  dv_t              x_dv,
    output logic             x_ready,
    input  y_t               y,
    input  dv_t              y_dv,
    output y_t               out_y,
    output logic             out_vld,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    output logic             err_ovf,
    output logic             err_proto
);

    localparam int                 AW      = $clog2(DEPTH);
    localparam logic [LVL_W-1:0]   FULL    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]   INF_MAX = '1;

    // Every in-flight result must have a reserved slot, so the buffer must
    // cover the pipeline depth plus one cycle of credit round trip.
    if (DEPTH < LATENCY + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("quadra_out_buf: DEPTH must be a power of 2 and at least LATENCY+2");
    end

    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [LVL_W-1:0] inflight_reg, inflight_next;
    logic             err_ovf_reg, err_proto_reg;

    logic             push, pop, full, wr_en, ovf;
    logic [LVL_W:0]   credit_sum;
    y_t               rd_data;

    assign push  = y_dv;
    assign pop   = out_vld & out_ready;
    assign full  = (level_reg == FULL);
    assign wr_en = push & (~full | pop);
    assign ovf   = push & full & ~pop;

    // Credit depends only on registered state, never on x_dv or out_ready.
    assign credit_sum = {1'b0, level_reg} + {1'b0, inflight_reg};
    assign x_ready    = (credit_sum < (LVL_W+1)'(DEPTH));

    assign out_vld   = (level_reg != '0);
    assign out_y     = out_vld ? rd_data : '0;
    assign level     = level_reg;
    assign err_ovf   = err_ovf_reg;
    assign err_proto = err_proto_reg;

    always_comb begin
        level_next = level_reg;
        case ({wr_en, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Late results (inflight already 0) and protocol-violating issues both saturate.
    always_comb begin
        inflight_next = inflight_reg;
        if (x_dv && !y_dv && inflight_reg != INF_MAX) begin
            inflight_next = inflight_reg + LVL_W'(1);
        end else if (!x_dv && y_dv && inflight_reg != '0) begin
            inflight_next = inflight_reg - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            inflight_reg  <= '0;
            err_ovf_reg   <= 1'b0;
            err_proto_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg    <= level_next;
            inflight_reg <= inflight_next;
            if (ovf) begin
                err_ovf_reg <= 1'b1;
            end
            if (x_dv && !x_ready) begin
                err_proto_reg <= 1'b1;
            end
        end
    end

    quadra_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (y),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_quadra_out_buf.sv
// Randomised, self-checking bench for quadra_out_buf with a queue-based
// reference model and a behavioural 3-cycle pipeline delay line.
module tb_quadra_out_buf;
    import quadra_pkg::*;

    localparam int DEPTH = QBUF_DEPTH;
    localparam int LAT   = QUADRA_LATENCY;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int INF_MAX = (1 << LVL_W) - 1;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    dv_t              x_dv = 1'b0;
    logic             x_ready;
    y_t               y = '0;
    dv_t              y_dv = 1'b0;
    y_t               out_y;
    logic             out_vld;
    logic             out_ready = 1'b0;
    logic [LVL_W-1:0] level;
    logic             err_ovf;
    logic             err_proto;

    int checks = 0;
    int failures = 0;

    // Reference model state
    y_t mq[$];
    int m_inflight = 0;
    bit m_ovf = 0;
    bit m_proto = 0;
    bit dl_dv[LAT];
    y_t dl_y[LAT];

    always #5 clk = ~clk;

    quadra_out_buf dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .x_dv      (x_dv),
        .x_ready   (x_ready),
        .y         (y),
        .y_dv      (y_dv),
        .out_y     (out_y),
        .out_vld   (out_vld),
        .out_ready (out_ready),
        .level     (level),
        .err_ovf   (err_ovf),
        .err_proto (err_proto)
    );

    function automatic bit model_x_ready();
        return (mq.size() + m_inflight) < DEPTH;
    endfunction

    function automatic y_t model_head();
        return (mq.size() != 0) ? mq[0] : y_t'(0);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_inflight = 0;
        m_ovf = 0;
        m_proto = 0;
        for (int i = 0; i < LAT; i++) begin
            dl_dv[i] = 0;
            dl_y[i] = '0;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, return 1 time unit after the edge.
    task automatic step(input bit issue, input y_t data, input bit rdy,
                        input bit frc, input y_t frc_y);
        bit pdv;
        bit m_xr;
        y_t py;
        y_t popped;
        pdv = dl_dv[LAT-1] | frc;
        py  = frc ? frc_y : dl_y[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            dl_dv[i] = dl_dv[i-1];
            dl_y[i]  = dl_y[i-1];
        end
        dl_dv[0] = issue;
        dl_y[0]  = data;
        x_dv = issue;
        y = py;
        y_dv = pdv;
        out_ready = rdy;
        m_xr = model_x_ready();
        if (issue && !m_xr) m_proto = 1;
        if (rdy && mq.size() != 0) begin
            popped = mq.pop_front();
            $display("xfer out_y=%04h level_before=%0d", popped, mq.size() + 1);
        end
        if (pdv) begin
            if (mq.size() < DEPTH) mq.push_back(py);
            else m_ovf = 1;
        end
        m_inflight = m_inflight + int'(issue) - int'(pdv);
        if (m_inflight < 0) m_inflight = 0;
        if (m_inflight > INF_MAX) m_inflight = INF_MAX;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        x_dv = 1'b0;
        y_dv = 1'b0;
        y = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        model_clear();
        #1;
        checks++;
        if (out_vld !== 1'b0 || out_y !== 16'h0 || level !== '0 || x_ready !== 1'b1 ||
            err_ovf !== 1'b0 || err_proto !== 1'b0) begin
            failures++;
            $display("FAIL reset_during: vld=%b y=%h lvl=%0d xr=%b ovf=%b proto=%b required 0 0 0 1 0 0",
                     out_vld, out_y, level, x_ready, err_ovf, err_proto);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        step(0, '0, 0, 0, '0);
        checks++;
        if (out_vld !== 1'b0 || out_y !== 16'h0 || level !== '0 || x_ready !== 1'b1 ||
            err_ovf !== 1'b0 || err_proto !== 1'b0) begin
            failures++;
            $display("FAIL reset_after: vld=%b y=%h lvl=%0d xr=%b ovf=%b proto=%b required 0 0 0 1 0 0",
                     out_vld, out_y, level, x_ready, err_ovf, err_proto);
        end
    endtask

    task automatic test_single();
        step(1, 16'h0015, 1, 0, '0);
        step(0, '0, 1, 0, '0);
        step(0, '0, 1, 0, '0);
        checks++;
        if (out_vld !== 1'b0) begin
            failures++;
            $display("FAIL single_early: out_vld=%b required 0 (no bypass)", out_vld);
        end
        step(0, '0, 1, 0, '0);
        checks++;
        if (out_vld !== 1'b1 || out_y !== 16'h0015) begin
            failures++;
            $display("FAIL single_out: out_vld=%b out_y=%h required 1 0015", out_vld, out_y);
        end
        step(0, '0, 1, 0, '0);
        checks++;
        if (out_vld !== 1'b0 || level !== '0) begin
            failures++;
            $display("FAIL single_drain: out_vld=%b level=%0d required 0 0", out_vld, level);
        end
    endtask

    task automatic test_backpressure();
        int issues = 0;
        bit iss;
        for (int n = 0; n < 20; n++) begin
            iss = model_x_ready();
            checks++;
            if (x_ready !== iss) begin
                failures++;
                $display("FAIL bp_credit cycle %0d: x_ready=%b required %b", n, x_ready, iss);
            end
            if (iss) issues++;
            step(iss, y_t'($urandom), 0, 0, '0);
        end
        checks++;
        if (issues != DEPTH || level !== LVL_W'(DEPTH) || err_ovf !== 1'b0 || x_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: issues=%0d level=%0d ovf=%b xr=%b required 8 8 0 0",
                     issues, level, err_ovf, x_ready);
        end
        step(0, '0, 1, 0, '0);
        checks++;
        if (level !== LVL_W'(DEPTH - 1) || x_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_one_credit: level=%0d xr=%b required 7 1", level, x_ready);
        end
        for (int n = 0; n < 20 && mq.size() != 0; n++) begin
            checks++;
            if (out_vld !== 1'b1 || out_y !== mq[0]) begin
                failures++;
                $display("FAIL bp_order: vld=%b out_y=%h required 1 %h", out_vld, out_y, mq[0]);
            end
            step(0, '0, 1, 0, '0);
        end
        checks++;
        if (level !== '0 || out_vld !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: level=%0d vld=%b required 0 0", level, out_vld);
        end
    endtask

    task automatic test_stream();
        int next = 0;
        bit started = 0;
        for (int i = 0; i < 110 && next < 100; i++) begin
            if (i < 100) begin
                checks++;
                if (x_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_credit cycle %0d: x_ready=%b required 1", i, x_ready);
                end
            end
            step(i < 100, y_t'(i), 1, 0, '0);
            if (out_vld === 1'b1) begin
                started = 1;
                checks++;
                if (out_y !== y_t'(next)) begin
                    failures++;
                    $display("FAIL stream_order: out_y=%0d required %0d", out_y, next);
                end
                next++;
            end else if (started && next < 100) begin
                checks++;
                failures++;
                $display("FAIL stream_gap: out_vld=0 required 1 before result %0d", next);
            end
        end
        checks++;
        if (next != 100) begin
            failures++;
            $display("FAIL stream_count: got %0d results required 100", next);
        end
    endtask

    task automatic test_random();
        bit iss, rdy;
        for (int n = 0; n < 300; n++) begin
            iss = model_x_ready() && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(iss, y_t'($urandom), rdy, 0, '0);
            checks++;
            if (out_vld !== (mq.size() != 0) || out_y !== model_head() ||
                level !== LVL_W'(mq.size()) || x_ready !== model_x_ready() ||
                err_ovf !== 1'b0 || err_proto !== 1'b0) begin
                failures++;
                $display("FAIL rand cycle %0d: vld=%b y=%h lvl=%0d xr=%b ovf=%b proto=%b required %b %h %0d %b 0 0",
                         n, out_vld, out_y, level, x_ready, err_ovf, err_proto,
                         mq.size() != 0, model_head(), mq.size(), model_x_ready());
            end
        end
        for (int n = 0; n < 20; n++) step(0, '0, 1, 0, '0);
    endtask

    task automatic test_errors();
        for (int n = 0; n < 20; n++) begin
            step(model_x_ready(), y_t'($urandom_range(0, 16'hA9)), 0, 0, '0);
        end
        checks++;
        if (level !== LVL_W'(DEPTH) || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL err_fill: level=%0d ovf=%b required 8 0", level, err_ovf);
        end
        step(0, '0, 0, 1, 16'h00AA);
        checks++;
        if (err_ovf !== 1'b1 || level !== LVL_W'(DEPTH) || err_proto !== 1'b0) begin
            failures++;
            $display("FAIL err_ovf: ovf=%b level=%0d proto=%b required 1 8 0", err_ovf, level, err_proto);
        end
        checks++;
        if (x_ready !== 1'b0) begin
            failures++;
            $display("FAIL err_credit: x_ready=%b required 0", x_ready);
        end
        step(1, 16'h0055, 0, 0, '0);
        checks++;
        if (err_proto !== 1'b1) begin
            failures++;
            $display("FAIL err_proto: err_proto=%b required 1", err_proto);
        end
        for (int n = 0; n < 4; n++) step(0, '0, 0, 0, '0);
        for (int n = 0; n < 20 && mq.size() != 0; n++) begin
            checks++;
            if (out_y === 16'h00AA || out_y !== mq[0]) begin
                failures++;
                $display("FAIL err_drain: out_y=%h required %h", out_y, mq[0]);
            end
            step(0, '0, 1, 0, '0);
        end
        checks++;
        if (err_ovf !== 1'b1 || err_proto !== 1'b1 || out_vld !== 1'b0) begin
            failures++;
            $display("FAIL err_sticky: ovf=%b proto=%b vld=%b required 1 1 0", err_ovf, err_proto, out_vld);
        end
        do_reset();
        checks++;
        if (err_ovf !== 1'b0 || err_proto !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: ovf=%b proto=%b required 0 0", err_ovf, err_proto);
        end
    endtask

    task automatic test_simul_reset();
        for (int n = 0; n < 5; n++) step(1, y_t'($urandom), 0, 0, '0);
        for (int n = 0; n < 3; n++) step(0, '0, 0, 0, '0);
        checks++;
        if (level !== LVL_W'(5)) begin
            failures++;
            $display("FAIL simul_fill: level=%0d required 5", level);
        end
        step(1, 16'h1234, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 1, 0, '0);
        checks++;
        if (level !== LVL_W'(5) || mq.size() != 5) begin
            failures++;
            $display("FAIL simul_pushpop: level=%0d required 5", level);
        end
        step(1, y_t'($urandom), 0, 0, '0);
        step(1, y_t'($urandom), 0, 0, '0);
        #2;
        rst_b = 1'b0;
        x_dv = 1'b0;
        y_dv = 1'b0;
        model_clear();
        #1;
        checks++;
        if (level !== '0 || out_vld !== 1'b0 || out_y !== 16'h0 || x_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_async_rst: level=%0d vld=%b y=%h xr=%b required 0 0 0 1",
                     level, out_vld, out_y, x_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step(0, '0, 1, 0, '0);
            checks++;
            if (out_vld !== 1'b0 || level !== '0) begin
                failures++;
                $display("FAIL simul_stale cycle %0d: vld=%b level=%0d required 0 0", n, out_vld, level);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_random();
        test_errors();
        test_simul_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
